// File: rtl/seq_div.sv
// -----------------------------------------------------------------------------
// seq_div -- multi-cycle radix-2 restoring integer divider (RV64M DIV/DIVU/
// REM/REMU and the W forms DIVW/DIVUW/REMW/REMUW).
//
// The divider works on operand magnitudes and fixes up signs on the final
// iteration. Divide-by-zero and signed overflow bypass the iteration loop and
// complete at the accept edge itself.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   request valid
//   in_ready   divider idle and able to accept a request
//   src1       dividend
//   src2       divisor
//   op_signed  1: signed operation, 0: unsigned
//   op_rem     1: return remainder, 0: return quotient
//   op_word    1: 32-bit W variant (honoured only when WORD_EN=1)
//   flush      abort any in-flight operation; wins over accept and output
//   out_valid  result valid
//   out_ready  consumer takes the result
//   result     quotient or remainder (registered)
// -----------------------------------------------------------------------------
module seq_div #(
  parameter int WIDTH   = 64,
  parameter bit WORD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             op_signed,
  input  logic             op_rem,
  input  logic             op_word,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  // Shift that moves a 32-bit word to the top of the datapath and back.
  localparam int WSH = (WIDTH > 32) ? (WIDTH - 32) : 0;
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] FULL_N = CW'(WIDTH);
  localparam logic [CW-1:0] WORD_N = CW'((WIDTH > 32) ? 32 : WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] FULL_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  // Most-negative 32-bit value after sign extension to WIDTH.
  localparam logic [WIDTH-1:0] WORD_MIN = ALL_ONES << 31;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] sext_word(input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] t;
    t = signed'(v << WSH);
    return unsigned'(t >>> WSH);
  endfunction

  function automatic logic [WIDTH-1:0] zext_word(input logic [WIDTH-1:0] v);
    return (v << WSH) >> WSH;
  endfunction

  function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
    return neg ? (~v + ONE) : v;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             rem_sel_q;
  logic             word_q;
  logic [WIDTH-1:0] result_q;

  // ---------------------------------------------------------------------------
  // Operand preparation (accept edge)
  // ---------------------------------------------------------------------------
  logic             word_eff;
  logic [WIDTH-1:0] a_ext;
  logic [WIDTH-1:0] b_ext;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             sgn_ovf;
  logic [WIDTH-1:0] special_raw;
  logic [WIDTH-1:0] special_res;

  always_comb begin
    word_eff = WORD_EN && op_word;
    a_ext    = src1;
    b_ext    = src2;
    if (word_eff) begin
      a_ext = op_signed ? sext_word(src1) : zext_word(src1);
      b_ext = op_signed ? sext_word(src2) : zext_word(src2);
    end
    a_neg    = op_signed && a_ext[WIDTH-1];
    b_neg    = op_signed && b_ext[WIDTH-1];
    a_mag    = negate_if(a_ext, a_neg);
    b_mag    = negate_if(b_ext, b_neg);

    div_zero = (b_ext == ZERO);
    sgn_ovf  = op_signed && (b_ext == ALL_ONES) &&
               (a_ext == (word_eff ? WORD_MIN : FULL_MIN));

    // Divide by zero: q = -1, r = dividend. Overflow: q = dividend, r = 0.
    if (div_zero) special_raw = op_rem ? a_ext : ALL_ONES;
    else          special_raw = op_rem ? ZERO  : a_ext;
    special_res = word_eff ? sext_word(special_raw) : special_raw;
  end

  // ---------------------------------------------------------------------------
  // One restoring iteration and final sign fixup
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   rem_ext;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] sel_res;
  logic [WIDTH-1:0] fin_res;

  always_comb begin
    // Partial remainder needs one extra bit after the shift.
    rem_ext = {rem_q, quo_q[WIDTH-1]};
    diff    = rem_ext - {1'b0, div_q};
    fits    = ~diff[WIDTH];
    rem_nx  = fits ? diff[WIDTH-1:0] : rem_ext[WIDTH-1:0];
    quo_nx  = {quo_q[WIDTH-2:0], fits};

    quo_fix = negate_if(quo_nx, neg_quo_q);
    rem_fix = negate_if(rem_nx, neg_rem_q);
    sel_res = rem_sel_q ? rem_fix : quo_fix;
    fin_res = word_q ? sext_word(sel_res) : sel_res;
  end

  // ---------------------------------------------------------------------------
  // Control and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_sel_q <= 1'b0;
      word_q    <= 1'b0;
      result_q  <= '0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (div_zero || sgn_ovf) begin
              state_q  <= DONE;
              result_q <= special_res;
            end else begin
              state_q   <= CALC;
              cnt_q     <= word_eff ? WORD_N : FULL_N;
              rem_q     <= '0;
              // Word dividends sit in the top half so the shift feeds them
              // into the remainder in 32 iterations.
              quo_q     <= word_eff ? (a_mag << WSH) : a_mag;
              div_q     <= b_mag;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              rem_sel_q <= op_rem;
              word_q    <= word_eff;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q  <= DONE;
            result_q <= fin_res;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_seq_div.sv
module tb_seq_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        op_signed;
  logic        op_rem;
  logic        op_word;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;

  always #5 clk = ~clk;

  seq_div #(.WIDTH(64), .WORD_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .op_signed (op_signed),
    .op_rem    (op_rem),
    .op_word   (op_word),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    bit          sgn;
    bit          rem;
    bit          word;
    logic [63:0] exp;
    int          lat;
  } op_t;

  op_t stim[$];
  op_t sb[$];

  function automatic void add_op(string name, logic [63:0] a, logic [63:0] b,
                                 bit sgn, bit rem, bit word,
                                 logic [63:0] exp, int lat);
    op_t o;
    o.name = name; o.a = a; o.b = b; o.sgn = sgn; o.rem = rem; o.word = word;
    o.exp = exp; o.lat = lat;
    stim.push_back(o);
  endfunction

  // Drive one request, record its expectation, wait (bounded) for out_valid.
  // lat counts edges from the accept edge (inclusive) to the first edge after
  // which out_valid is seen high.
  task automatic do_op(input op_t o, output logic [63:0] res, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    src1 = o.a; src2 = o.b; op_signed = o.sgn; op_rem = o.rem; op_word = o.word;
    in_valid = 1'b1;
    sb.push_back(o);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
  endtask

  // Accept a request without waiting for its result.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    src1 = a; src2 = b; op_signed = 1'b0; op_rem = 1'b0; op_word = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    src1 = '0; src2 = '0; op_signed = 1'b0; op_rem = 1'b0; op_word = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (result !== 64'd0) $display("FAIL reset_result: got %h want 0", result);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_table(input string tag);
    op_t o, e;
    logic [63:0] r;
    int l;
    while (stim.size() != 0) begin
      o = stim.pop_front();
      do_op(o, r, l);
      e = sb.pop_front();
      n_checks++;
      if (r !== e.exp) $display("FAIL %s/%s result: got %h want %h", tag, e.name, r, e.exp);
      else n_pass++;
      n_checks++;
      if (l != e.lat) $display("FAIL %s/%s latency: got %0d want %0d", tag, e.name, l, e.lat);
      else n_pass++;
    end
  endtask

  task automatic test_unsigned();
    add_op("divu_100_7", 64'd100, 64'd7, 0, 0, 0, 64'd14, 65);
    add_op("remu_100_7", 64'd100, 64'd7, 0, 1, 0, 64'd2, 65);
    add_op("divu_max_3", '1, 64'd3, 0, 0, 0, 64'h5555_5555_5555_5555, 65);
    add_op("remu_max_16", '1, 64'd16, 0, 1, 0, 64'd15, 65);
    add_op("divu_small_big", 64'd5, 64'd9, 0, 0, 0, 64'd0, 65);
    test_table("unsigned");
  endtask

  task automatic test_signed();
    add_op("div_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    add_op("rem_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    add_op("div_7_m2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    add_op("rem_7_m2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1, 0, 64'd1, 65);
    add_op("div_m7_m2", 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 64'd3, 65);
    add_op("div_min_2", 64'h8000_0000_0000_0000, 64'd2, 1, 0, 0, 64'hC000_0000_0000_0000, 65);
    test_table("signed");
  endtask

  task automatic test_special();
    add_op("divu_5_0", 64'd5, 64'd0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    add_op("remu_5_0", 64'd5, 64'd0, 0, 1, 0, 64'd5, 1);
    add_op("div_min_m1", 64'h8000_0000_0000_0000, '1, 1, 0, 0, 64'h8000_0000_0000_0000, 1);
    add_op("rem_min_m1", 64'h8000_0000_0000_0000, '1, 1, 1, 0, 64'd0, 1);
    add_op("rem_m5_0", 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFB, 1);
    test_table("special");
  endtask

  task automatic test_word();
    add_op("divuw_ffff_1", 64'h1234_5678_FFFF_FFFF, 64'd1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    add_op("divw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 0, 1,
           64'hFFFF_FFFF_8000_0000, 1);
    add_op("remw_7_0", 64'd7, 64'd0, 1, 1, 1, 64'd7, 1);
    add_op("divw_m7_2_hi", 64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_0000_0000_0002, 1, 0, 1,
           64'hFFFF_FFFF_FFFF_FFFD, 33);
    add_op("remuw_ffff_16", 64'hABCD_0000_FFFF_FFFF, 64'd16, 0, 1, 1, 64'd15, 33);
    add_op("divuw_8000_1", 64'h0000_0000_8000_0000, 64'hFFFF_0000_0000_0001, 0, 0, 1,
           64'hFFFF_FFFF_8000_0000, 33);
    add_op("divuw_by0_hi", 64'd9, 64'hFFFF_FFFF_0000_0000, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    test_table("word");
  endtask

  task automatic test_random();
    logic [63:0] a, b;
    longint sa, sbv;
    for (int i = 0; i < 8; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 60);
      if (b == 64'd0) b = 64'd1;
      if (i < 4) begin
        add_op("rnd_divu", a, b, 0, 0, 0, a / b, 65);
        add_op("rnd_remu", a, b, 0, 1, 0, a % b, 65);
      end else begin
        sa = a; sbv = b;
        if (i[0]) sbv = -sbv;
        add_op("rnd_div", a, sbv, 1, 0, 0, sa / sbv, 65);
        add_op("rnd_rem", a, sbv, 1, 1, 0, sa % sbv, 65);
      end
    end
    test_table("random");
  endtask

  task automatic test_flush();
    bit seen;
    start_op(64'hFFFF_0000_1234_5678, 64'd77);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_calc: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    else n_pass++;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL flush_no_result: out_valid seen=1 want 0");
    else n_pass++;

    add_op("divu_9_3_after_flush", 64'd9, 64'd3, 0, 0, 0, 64'd3, 65);
    test_table("flush");

    // flush with in_valid while idle must not accept (div-by-zero would finish at once)
    @(negedge clk);
    src1 = 64'd5; src2 = 64'd0; op_signed = 1'b0; op_rem = 1'b0; op_word = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL flush_blocks_accept: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    else n_pass++;

    // flush in DONE drops the pending result
    out_ready = 1'b0;
    add_op("divu_5_0_hold", 64'd5, 64'd0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    test_table("flush_done");
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_done: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    add_op("divu_100_7_bp", 64'd100, 64'd7, 0, 0, 0, 64'd14, 65);
    test_table("bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || result !== 64'd14 || in_ready !== 1'b0)
        $display("FAIL bp_hold_%0d: out_valid=%b result=%h in_ready=%b want 1/%h/0",
                 i, out_valid, result, in_ready, 64'd14);
      else n_pass++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    start_op(64'd1000, 64'd3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || result !== 64'd0 || in_ready !== 1'b0)
      $display("FAIL reset_mid: out_valid=%b result=%h in_ready=%b want 0/0/0",
               out_valid, result, in_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    add_op("divu_after_reset", 64'd1000, 64'd3, 0, 0, 0, 64'd333, 65);
    test_table("reset_mid");
  endtask

  task automatic test_back_to_back();
    op_t o, e;
    logic [63:0] r;
    int l;
    add_op("b2b_0", 64'd50, 64'd5, 0, 0, 0, 64'd10, 65);
    add_op("b2b_1", 64'd50, 64'd0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    add_op("b2b_2", 64'hFFFF_FFFF_FFFF_FFCE, 64'd5, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFF6, 33);
    add_op("b2b_3", 64'd51, 64'd5, 0, 1, 0, 64'd1, 65);
    while (stim.size() != 0) begin
      o = stim.pop_front();
      do_op(o, r, l);
      e = sb.pop_front();
      n_checks++;
      if (r !== e.exp || l != e.lat)
        $display("FAIL b2b/%s: result=%h lat=%0d want %h lat=%0d", e.name, r, l, e.exp, e.lat);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b0)
        $display("FAIL b2b/%s in_ready_in_done: got %b want 0", e.name, in_ready);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_word();
    test_random();
    test_flush();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
